// File: rtl/gray_counter_if.sv
// rtl/gray_counter_if.sv - control and count bundle between a gray_counter and its user
//
// Signals:
//   en        advance counter one step this cycle
//   up_dn     direction: 1 = up, 0 = down
//   load      load counter from load_bin this cycle
//   load_bin  binary value to load (N bits)
//   gray_out  registered Gray count (N bits)
//   bin_out   registered binary count matching gray_out (N bits)
//   tc        terminal count for the current direction
//   wrap      registered pulse, high the cycle after the count wraps
//   step      registered pulse, high the cycle after any en-driven advance
// Modports: master drives the controls, slave is the counter.
interface gray_counter_if #(
    parameter int N = 4
);
    logic         en;
    logic         up_dn;
    logic         load;
    logic [N-1:0] load_bin;
    logic [N-1:0] gray_out;
    logic [N-1:0] bin_out;
    logic         tc;
    logic         wrap;
    logic         step;

    modport master (
        output en, up_dn, load, load_bin,
        input  gray_out, bin_out, tc, wrap, step
    );

    modport slave (
        input  en, up_dn, load, load_bin,
        output gray_out, bin_out, tc, wrap, step
    );
endinterface

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered N-bit up/down Gray counter with load, terminal count and wrap/step pulses
//
// Ports:
//   clk  single system clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  gray_counter_if.slave: en/up_dn/load/load_bin in,
//        gray_out/bin_out/tc/wrap/step out
// Priority each edge: rst > load > en > hold.
module gray_counter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    gray_counter_if.slave  bus
);
    logic [N-1:0] b;
    logic [N-1:0] g;
    logic [N-1:0] b_next;
    logic         at_end;
    logic         wrap_q;
    logic         step_q;

    // Last value in the current direction: all ones going up, zero going down.
    // Shared by the live tc output and the registered wrap decision.
    assign at_end = bus.up_dn ? (&b) : ~(|b);

    always_comb begin
        b_next = b;
        if (bus.load) begin
            b_next = bus.load_bin;
        end else if (bus.en) begin
            b_next = bus.up_dn ? (b + 1'b1) : (b - 1'b1);
        end
    end

    // Gray is registered from the same next binary value so gray_out and
    // bin_out always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            b      <= '0;
            g      <= '0;
            wrap_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            b      <= b_next;
            g      <= b_next ^ (b_next >> 1);
            step_q <= bus.en & ~bus.load;
            wrap_q <= bus.en & ~bus.load & at_end;
        end
    end

    assign bus.bin_out  = b;
    assign bus.gray_out = g;
    assign bus.tc       = at_end;
    assign bus.wrap     = wrap_q;
    assign bus.step     = step_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter
module tb_gray_counter;
    localparam int N = 4;
    localparam int M = 1 << N;

    logic clk = 1'b0;
    logic rst;

    gray_counter_if #(.N(N)) bus ();

    gray_counter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: integer count, pulses and the gray value before the last advance.
    int mb      = 0;
    bit mwrap   = 0;
    bit mstep   = 0;
    bit madv    = 0;
    int mprev_g = 0;
    bit model_valid = 0;

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Gray-to-binary by prefix XOR from the MSB, as a downstream converter would do.
    function automatic int from_gray(input int gv);
        int r;
        int bitv;
        r = 0;
        bitv = 0;
        for (int i = N - 1; i >= 0; i--) begin
            bitv = bitv ^ ((gv >> i) & 1);
            r = r | (bitv << i);
        end
        return r;
    endfunction

    function automatic int popcount(input int v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += (v >> i) & 1;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, let the DUT sample them, advance the model,
    // then move 1 time unit past the edge before anything changes again.
    task automatic cycle(input bit r, input bit e, input bit u, input bit l, input int lb);
        int old;
        rst          = r;
        bus.en       = e;
        bus.up_dn    = u;
        bus.load     = l;
        bus.load_bin = lb[N-1:0];
        @(posedge clk);
        old = mb;
        madv = 0;
        if (r) begin
            mb = 0; mwrap = 0; mstep = 0;
        end else if (l) begin
            mb = lb % M; mwrap = 0; mstep = 0;
        end else if (e) begin
            mb = u ? (mb + 1) % M : (mb + M - 1) % M;
            mstep = 1;
            mwrap = u ? (old == M - 1) : (old == 0);
            madv = 1;
            mprev_g = to_gray(old);
        end else begin
            mwrap = 0; mstep = 0;
        end
        model_valid = 1;
        #1;
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            int exp_tc;
            exp_tc = bus.up_dn ? (mb == M - 1) : (mb == 0);
            check("bin_out", int'(bus.bin_out), mb);
            check("gray_out", int'(bus.gray_out), to_gray(mb));
            check("tc", int'(bus.tc), exp_tc);
            check("wrap", int'(bus.wrap), int'(mwrap));
            check("step", int'(bus.step), int'(mstep));
            check("converter", from_gray(int'(bus.gray_out)), int'(bus.bin_out));
            if (madv) check("one_bit_change", popcount(int'(bus.gray_out) ^ mprev_g), 1);
        end
    end

    int up_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.up_dn = 1'b1;
        bus.load = 1'b0;
        bus.load_bin = '0;

        // Reset with en held high.
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check("rst_gray", int'(bus.gray_out), 0);
        check("rst_bin", int'(bus.bin_out), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        check("rst_step", int'(bus.step), 0);
        check("rst_tc", int'(bus.tc), 0);

        // Full up count from zero against the literal Gray sequence.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 1, 0, 0);
            check("up_seq_gray", int'(bus.gray_out), up_seq[i]);
            check("up_seq_wrap", int'(bus.wrap), (i == 15) ? 1 : 0);
            check("up_seq_tc", int'(bus.tc), (i == 14) ? 1 : 0);
        end

        // Down wrap out of reset.
        cycle(1, 0, 0, 0, 0);
        check("down_tc_before", int'(bus.tc), 1);
        cycle(0, 1, 0, 0, 0);
        check("down_wrap_bin", int'(bus.bin_out), 15);
        check("down_wrap_gray", int'(bus.gray_out), 8);
        check("down_wrap_pulse", int'(bus.wrap), 1);

        // Load beats en.
        cycle(0, 1, 1, 1, 6);
        check("load_bin", int'(bus.bin_out), 6);
        check("load_gray", int'(bus.gray_out), 5);
        check("load_step", int'(bus.step), 0);
        cycle(0, 1, 1, 0, 0);
        check("after_load_bin", int'(bus.bin_out), 7);
        check("after_load_gray", int'(bus.gray_out), 4);
        check("after_load_step", int'(bus.step), 1);

        // Reset mid-count, then resume from zero.
        cycle(0, 0, 1, 1, 9);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        check("mid_bin", int'(bus.bin_out), 11);
        cycle(1, 1, 1, 0, 0);
        check("mid_rst_bin", int'(bus.bin_out), 0);
        check("mid_rst_wrap", int'(bus.wrap), 0);
        check("mid_rst_step", int'(bus.step), 0);
        cycle(0, 1, 1, 0, 0);
        check("resume_bin", int'(bus.bin_out), 1);

        // Full up and down sweeps (converter cross-check runs every cycle).
        for (int i = 0; i < M; i++) cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < M; i++) cycle(0, 1, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, u, l;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 8);
            e = ($urandom_range(0, 99) < 70);
            u = ($urandom_range(0, 99) < 60);
            cycle(r, e, u, l, int'($urandom_range(0, M - 1)));
        end

        cycle(0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
